// File: rtl/serv_rf_pkg.sv
// ============================================================================
// Module      : serv_rf_pkg
// Description : Shared types and sizing helpers for the two-read register-file RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serv_rf_pkg;

    localparam int GPR_COUNT = 32;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    // Words needed to hold all GPRs plus CSR slots, 32 bits each, at slice width w.
    function automatic int rf_depth(input int w, input int n_csr);
        return (GPR_COUNT + n_csr) * 32 / w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serv_rf_clr_seq.sv
// ============================================================================
// Module      : serv_rf_clr_seq
// Description : Post-reset clear sequencer; walks every address once, then ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serv_rf_clr_seq
    import serv_rf_pkg::*;
#(
    parameter int depth = 576,
    parameter int aw    = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_clr_we,
    output logic [aw-1:0] o_clr_addr,
    output logic          o_ready
);

    localparam logic [aw-1:0] c_LAST = aw'(depth - 1);

    rf_state_t     r_state;
    rf_state_t     w_state_nxt;
    logic [aw-1:0] r_cnt;
    logic [aw-1:0] w_cnt_nxt;
    logic          r_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (r_state == RF_READY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == RF_CLEAR) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                w_state_nxt = RF_READY;
            end
        end
    end

    assign o_clr_we   = (r_state == RF_CLEAR);
    assign o_clr_addr = r_cnt;
    assign o_ready    = r_ready;

endmodule

`default_nettype wire

// File: rtl/serv_rf_ram_2r.sv
// ============================================================================
// Module      : serv_rf_ram_2r
// Description : 1W/2R register-file RAM with x0 gating, write-first bypass and
//               post-reset clear. Optional parity via SERV_RF_RAM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serv_rf_ram_2r
    import serv_rf_pkg::*;
#(
    parameter int width    = 2,
    parameter int csr_regs = 4,
    parameter int depth    = rf_depth(width, csr_regs),
    parameter int aw       = $clog2(depth)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_ready,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr0,
    input  logic             i_ren0,
    output logic [width-1:0] o_rdata0,
    input  logic [aw-1:0]    i_raddr1,
    input  logic             i_ren1,
    output logic [width-1:0] o_rdata1,
    output logic             o_perr
);

    // Lowest address bit that selects the register number rather than the slice.
    localparam int c_XLSB = 5 - $clog2(width);
`ifdef SERV_RF_RAM_PARITY_EN
    localparam int c_MW = width + 1;
`else
    localparam int c_MW = width;
`endif

    logic [c_MW-1:0]  r_mem [depth];

    logic             w_clr_we;
    logic [aw-1:0]    w_clr_addr;
    logic             w_run;
    logic             w_we;
    logic [aw-1:0]    w_waddr;
    logic [width-1:0] w_wdata;
    logic [c_MW-1:0]  w_wword;

    serv_rf_clr_seq #(
        .depth (depth),
        .aw    (aw)
    ) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (o_ready)
    );

    assign w_run   = ~w_clr_we;
    assign w_we    = w_clr_we | (i_wen & w_run);
    assign w_waddr = w_clr_we ? w_clr_addr : i_waddr;
    assign w_wdata = w_clr_we ? '0 : i_wdata;
`ifdef SERV_RF_RAM_PARITY_EN
    assign w_wword = {^w_wdata, w_wdata};
`else
    assign w_wword = w_wdata;
`endif

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wword;
        end
    end

    logic             w_zero0, w_zero1;
    logic             w_byp0, w_byp1;
    logic [c_MW-1:0]  w_rword0, w_rword1;
    logic [width-1:0] r_rdata0, r_rdata1;
    logic             r_zero0, r_zero1;

    assign w_zero0  = ~(|i_raddr0[aw-1:c_XLSB]);
    assign w_zero1  = ~(|i_raddr1[aw-1:c_XLSB]);
    assign w_byp0   = w_run & i_wen & (i_raddr0 == i_waddr);
    assign w_byp1   = w_run & i_wen & (i_raddr1 == i_waddr);
    assign w_rword0 = r_mem[i_raddr0];
    assign w_rword1 = r_mem[i_raddr1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata0 <= '0;
            r_zero0  <= 1'b0;
            r_rdata1 <= '0;
            r_zero1  <= 1'b0;
        end else if (w_clr_we) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (i_ren0) begin
                r_rdata0 <= w_byp0 ? i_wdata : w_rword0[width-1:0];
                r_zero0  <= w_zero0;
            end
            if (i_ren1) begin
                r_rdata1 <= w_byp1 ? i_wdata : w_rword1[width-1:0];
                r_zero1  <= w_zero1;
            end
        end
    end

    assign o_rdata0 = r_rdata0 & ~{width{r_zero0}};
    assign o_rdata1 = r_rdata1 & ~{width{r_zero1}};

`ifdef SERV_RF_RAM_PARITY_EN
    logic r_perr;
    logic w_perr_hit;

    // Bypassed data never came from the array, so only real array reads are checked.
    assign w_perr_hit = w_run & ((i_ren0 & ~w_zero0 & ~w_byp0 & (^w_rword0)) |
                                 (i_ren1 & ~w_zero1 & ~w_byp1 & (^w_rword1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perr <= 1'b0;
        end else if (w_perr_hit) begin
            r_perr <= 1'b1;
        end
    end

    assign o_perr = r_perr;
`else
    assign o_perr = 1'b0;
`endif

endmodule

`default_nettype wire
